// File: rtl/ddr3_read_arbiter_pkg.sv
// Shared definitions for the DDR3 DMA read arbiter.
// Holds the default address width, the requester count, the fixed ID width,
// the arbiter FSM state encoding, and the round-robin pointer increment helper.
package ddr3_dma_pkg;

    localparam int DMA_ADDR_WIDTH = 27;
    localparam int NUM_REQ        = 16;
    localparam int ID_WIDTH       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Next round-robin start position: one past the granted index, wrapping at num_req.
    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] idx,
                                                     input int                  num_req);
        if (int'(idx) >= num_req - 1) begin
            return {ID_WIDTH{1'b0}};
        end else begin
            return idx + {{(ID_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ddr3_read_arbiter_if.sv
// Handshake bundle between the requesters / DMA read engine and the arbiter.
//   read_req, read_start_addr, read_length : requester side (flattened per requester)
//   read_ack                               : one-cycle grant pulse per requester
//   cmd_valid/cmd_ready/cmd_addr/cmd_length/cmd_id : downstream read command
//   rd_eop                                 : end-of-packet from the read data path
// master = arbiter side, slave = requesters plus downstream engine.
interface ddr3_read_arbiter_if
    import ddr3_dma_pkg::*;
#(
    parameter int DMA_ADDR_WIDTH = ddr3_dma_pkg::DMA_ADDR_WIDTH,
    parameter int NUM_REQ        = ddr3_dma_pkg::NUM_REQ
);
    logic [NUM_REQ-1:0]                read_req;
    logic [NUM_REQ*DMA_ADDR_WIDTH-1:0] read_start_addr;
    logic [NUM_REQ*DMA_ADDR_WIDTH-1:0] read_length;
    logic [NUM_REQ-1:0]                read_ack;
    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [DMA_ADDR_WIDTH-1:0]         cmd_addr;
    logic [DMA_ADDR_WIDTH-1:0]         cmd_length;
    logic [ID_WIDTH-1:0]               cmd_id;
    logic                              rd_eop;

    modport master (
        input  read_req, read_start_addr, read_length, cmd_ready, rd_eop,
        output read_ack, cmd_valid, cmd_addr, cmd_length, cmd_id
    );

    modport slave (
        output read_req, read_start_addr, read_length, cmd_ready, rd_eop,
        input  read_ack, cmd_valid, cmd_addr, cmd_length, cmd_id
    );

endinterface

// File: rtl/ddr3_read_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector, bit i = requester i
//   ptr   : index holding highest priority this round
//   grant : first requesting index at or above ptr, wrapping modulo NUM_REQ
//   any   : at least one request present (grant is meaningless otherwise)
module rr_pick
    import ddr3_dma_pkg::*;
#(
    parameter int NUM_REQ = ddr3_dma_pkg::NUM_REQ
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant,
    output logic                any
);

    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int                  offset);
        return ID_WIDTH'((int'(base) + offset) % NUM_REQ);
    endfunction

    // Scan from the farthest offset down to ptr so the nearest requester is written last and wins.
    always_comb begin
        grant = {ID_WIDTH{1'b0}};
        any   = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(ptr, i)]) begin
                grant = wrap_idx(ptr, i);
                any   = 1'b1;
            end else begin
                grant = grant;
                any   = any;
            end
        end
    end

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Round-robin read arbiter in front of a DDR3 DMA read engine.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : requester / command / end-of-packet bundle (master side)
//   busy       : high whenever a grant is being issued or awaiting end-of-packet
//   err_eop    : sticky flag, end-of-packet arrived while no command was outstanding
// One command is outstanding at most; zero-length requests are acked and
// retired in IDLE without touching the downstream engine.
module ddr3_read_arbiter
    import ddr3_dma_pkg::*;
#(
    parameter int DMA_ADDR_WIDTH = ddr3_dma_pkg::DMA_ADDR_WIDTH,
    parameter int NUM_REQ        = ddr3_dma_pkg::NUM_REQ
) (
    input  logic                clk,
    input  logic                rst_n,
    ddr3_read_arbiter_if.master bus,
    output logic                busy,
    output logic                err_eop
);

    localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e                state_r;
    logic [ID_WIDTH-1:0]       rr_ptr_r;
    logic [ID_WIDTH-1:0]       grant_s;
    logic                      any_s;
    logic [DMA_ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
    logic [DMA_ADDR_WIDTH-1:0] len_arr_s  [NUM_REQ];
    logic [DMA_ADDR_WIDTH-1:0] sel_addr_s;
    logic [DMA_ADDR_WIDTH-1:0] sel_len_s;
    logic                      zero_len_s;

    logic [NUM_REQ-1:0]        read_ack_r;
    logic                      cmd_valid_r;
    logic [DMA_ADDR_WIDTH-1:0] cmd_addr_r;
    logic [DMA_ADDR_WIDTH-1:0] cmd_length_r;
    logic [ID_WIDTH-1:0]       cmd_id_r;
    logic                      busy_r;
    logic                      err_eop_r;

    // Unflatten the per-requester address and length buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr_s[g] = bus.read_start_addr[g*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
        assign len_arr_s[g]  = bus.read_length[g*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (bus.read_req),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .any   (any_s)
    );

    assign sel_addr_s = addr_arr_s[grant_s];
    assign sel_len_s  = len_arr_s[grant_s];
    assign zero_len_s = (sel_len_s == {DMA_ADDR_WIDTH{1'b0}});

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {ID_WIDTH{1'b0}};
            read_ack_r   <= {NUM_REQ{1'b0}};
            cmd_valid_r  <= 1'b0;
            cmd_addr_r   <= {DMA_ADDR_WIDTH{1'b0}};
            cmd_length_r <= {DMA_ADDR_WIDTH{1'b0}};
            cmd_id_r     <= {ID_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            err_eop_r    <= 1'b0;
        end else begin
            read_ack_r <= {NUM_REQ{1'b0}};
            // WAIT is the only state in which an end-of-packet is expected.
            if (bus.rd_eop && (state_r != ST_WAIT)) begin
                err_eop_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        read_ack_r   <= ACK_ONE << grant_s;
                        cmd_addr_r   <= sel_addr_s;
                        cmd_length_r <= sel_len_s;
                        cmd_id_r     <= grant_s;
                        if (zero_len_s) begin
                            // Nothing to fetch: retire immediately and rotate.
                            rr_ptr_r <= next_ptr(grant_s, NUM_REQ);
                        end else begin
                            state_r     <= ST_ISSUE;
                            cmd_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.cmd_ready) begin
                        state_r     <= ST_WAIT;
                        cmd_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.rd_eop) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= next_ptr(cmd_id_r, NUM_REQ);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_ack   = read_ack_r;
    assign bus.cmd_valid  = cmd_valid_r;
    assign bus.cmd_addr   = cmd_addr_r;
    assign bus.cmd_length = cmd_length_r;
    assign bus.cmd_id     = cmd_id_r;
    assign busy           = busy_r;
    assign err_eop        = err_eop_r;

endmodule
